// File: rtl/rgmii_pkg.sv
// Shared definitions for the RGMII receive path: Ethernet framing constants,
// CRC-32 parameters and step function, FSM state and per-frame status payload.
// No ports (package).
package rgmii_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned LEN_W  = 16;
   localparam int unsigned CNT_W  = 32;
   localparam int unsigned CRC_W  = 32;
   localparam int unsigned PCNT_W = 3;

   localparam logic [CRC_W-1:0]  CRC32_POLY_REFL = 32'hEDB88320;
   localparam logic [CRC_W-1:0]  CRC32_INIT      = 32'hFFFFFFFF;
   localparam logic [CRC_W-1:0]  CRC32_RESIDUE   = 32'hDEBB20E3;
   localparam logic [DATA_W-1:0] ETH_PREAMBLE    = 8'h55;
   localparam logic [DATA_W-1:0] ETH_SFD         = 8'hD5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_DATA = 2'd2,
      ST_DROP = 2'd3
   } rx_state_e;

   typedef struct packed {
      logic             good;
      logic             crc_err;
      logic             len_err;
      logic             phy_err;
      logic             pre_err;
      logic             abort;
      logic [LEN_W-1:0] len;
   } rx_status_t;

   // One byte of reflected CRC-32, LSB first.
   function automatic logic [CRC_W-1:0] crc32_step(input logic [CRC_W-1:0]  crc,
                                                   input logic [DATA_W-1:0] data);
      logic [CRC_W-1:0] c;
      c = crc ^ CRC_W'(data);
      for (int i = 0; i < int'(DATA_W); i++) begin
         c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
      end
      return c;
   endfunction

   // Status record; good is derived so it can never disagree with the flags.
   function automatic rx_status_t make_status(input logic             crc_err,
                                              input logic             len_err,
                                              input logic             phy_err,
                                              input logic             pre_err,
                                              input logic             abort,
                                              input logic [LEN_W-1:0] len);
      rx_status_t s;
      s.crc_err = crc_err;
      s.len_err = len_err;
      s.phy_err = phy_err;
      s.pre_err = pre_err;
      s.abort   = abort;
      s.len     = len;
      s.good    = ~(crc_err | len_err | phy_err | pre_err | abort);
      return s;
   endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide CRC-32 accumulator: combinational 8-bit step plus the running register.
// Ports: clk/rst (sync, active-high), init_i loads CRC32_INIT, en_i folds data_i
// into the register, crc_next_c is the register value with data_i already folded in.
module crc32_d8
   import rgmii_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              init_i,
   input  logic              en_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [CRC_W-1:0]  crc_next_c
);

   logic [CRC_W-1:0] crc_q;
   logic [CRC_W-1:0] crc_d;

   assign crc_d      = crc32_step(crc_q, data_i);
   assign crc_next_c = crc_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         crc_q <= CRC32_INIT;
      end else if (init_i) begin
         crc_q <= CRC32_INIT;
      end else if (en_i) begin
         crc_q <= crc_d;
      end
   end

endmodule

// File: rtl/rgmii_rx_frame_checker.sv
// RX frame checker behind the RGMII receiver: strips preamble/SFD and FCS,
// checks FCS, length and PHY error, streams DA..last data byte, reports status.
// Ports: clk125/rst (sync, active-high); i_* receive byte stream (qualified by
// i_val); o_* payload stream; st_* one-cycle status strobe and fields;
// cnt_good/cnt_bad wrapping frame counters.
module rgmii_rx_frame_checker
   import rgmii_pkg::*;
#(
   parameter int unsigned MIN_LEN = 64,
   parameter int unsigned MAX_LEN = 1518
) (
   input  logic              clk125,
   input  logic              rst,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_val,
   input  logic              i_err,
   input  logic              i_sof,
   input  logic              i_eof,
   output logic [DATA_W-1:0] o_data,
   output logic              o_val,
   output logic              o_sof,
   output logic              o_eof,
   output logic              st_val,
   output logic              st_good,
   output logic              st_crc_err,
   output logic              st_len_err,
   output logic              st_phy_err,
   output logic              st_pre_err,
   output logic              st_abort,
   output logic [LEN_W-1:0]  st_len,
   output logic [CNT_W-1:0]  cnt_good,
   output logic [CNT_W-1:0]  cnt_bad
);

   localparam logic [LEN_W-1:0]  MIN_LEN_L = LEN_W'(MIN_LEN);
   localparam logic [LEN_W-1:0]  MAX_LEN_L = LEN_W'(MAX_LEN);
   localparam logic [PCNT_W-1:0] PRE_MAX   = PCNT_W'(7);
   localparam logic [2:0]        DL_FULL   = 3'd4;

   rx_state_e               state_q;
   logic [PCNT_W-1:0]       pre_cnt_q;
   logic [3:0][DATA_W-1:0]  dl_q;
   logic [2:0]              dl_cnt_q;
   logic                    started_q;
   logic                    phy_q;
   logic [LEN_W-1:0]        len_q;
   logic [DATA_W-1:0]       o_data_q;
   logic                    o_val_q;
   logic                    o_sof_q;
   logic                    o_eof_q;
   logic                    st_val_q;
   rx_status_t              st_q;
   logic [CNT_W-1:0]        cnt_good_q;
   logic [CNT_W-1:0]        cnt_bad_q;

   logic                    sof_bad_c;
   logic [LEN_W-1:0]        len_inc_c;
   logic                    len_err_c;
   logic                    crc_init_c;
   logic                    crc_en_c;
   logic [CRC_W-1:0]        crc_next_c;

   // A SoF byte is rejected if it is not preamble or already ends the frame.
   assign sof_bad_c  = i_eof | (i_data != ETH_PREAMBLE);
   assign len_inc_c  = (len_q == {LEN_W{1'b1}}) ? len_q : len_q + LEN_W'(1);
   assign len_err_c  = (len_inc_c < MIN_LEN_L) | (len_inc_c > MAX_LEN_L);
   assign crc_init_c = i_val & ~i_sof & (state_q == ST_PRE) & (i_data == ETH_SFD);
   assign crc_en_c   = i_val & ~i_sof & (state_q == ST_DATA);

   crc32_d8 u_crc (
      .clk        (clk125),
      .rst        (rst),
      .init_i     (crc_init_c),
      .en_i       (crc_en_c),
      .data_i     (i_data),
      .crc_next_c (crc_next_c)
   );

   // Frame FSM, delay line, status and counters.
   always_ff @(posedge clk125) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pre_cnt_q  <= '0;
         dl_q       <= '0;
         dl_cnt_q   <= '0;
         started_q  <= 1'b0;
         phy_q      <= 1'b0;
         len_q      <= '0;
         o_data_q   <= '0;
         o_val_q    <= 1'b0;
         o_sof_q    <= 1'b0;
         o_eof_q    <= 1'b0;
         st_val_q   <= 1'b0;
         st_q       <= '0;
         cnt_good_q <= '0;
         cnt_bad_q  <= '0;
      end else begin
         o_val_q  <= 1'b0;
         o_sof_q  <= 1'b0;
         o_eof_q  <= 1'b0;
         st_val_q <= 1'b0;

         if (st_val_q) begin
            if (st_q.good) cnt_good_q <= cnt_good_q + CNT_W'(1);
            else           cnt_bad_q  <= cnt_bad_q + CNT_W'(1);
         end

         if (i_val) begin
            if (i_sof) begin
               // Any SoF outside IDLE aborts the frame in flight; the new byte
               // is then handled exactly as an IDLE SoF.
               if (state_q != ST_IDLE) begin
                  st_val_q <= 1'b1;
                  st_q     <= make_status(1'b0, 1'b0, phy_q, 1'b0, 1'b1, len_q);
                  o_eof_q  <= (state_q == ST_DATA) & started_q;
               end
               dl_cnt_q  <= '0;
               started_q <= 1'b0;
               len_q     <= '0;
               phy_q     <= i_err;
               pre_cnt_q <= PCNT_W'(1);
               if (sof_bad_c) begin
                  // Abort status already occupies this strobe slot.
                  if (state_q == ST_IDLE) begin
                     st_val_q <= 1'b1;
                     st_q     <= make_status(1'b0, 1'b0, i_err, 1'b1, 1'b0, LEN_W'(0));
                  end
                  state_q <= i_eof ? ST_IDLE : ST_DROP;
               end else begin
                  state_q <= ST_PRE;
               end
            end else begin
               case (state_q)
                  ST_PRE: begin
                     phy_q <= phy_q | i_err;
                     if (i_eof || ((i_data != ETH_SFD) &&
                                   ((i_data != ETH_PREAMBLE) || (pre_cnt_q == PRE_MAX)))) begin
                        st_val_q <= 1'b1;
                        st_q     <= make_status(1'b0, 1'b0, phy_q | i_err, 1'b1, 1'b0, LEN_W'(0));
                        state_q  <= i_eof ? ST_IDLE : ST_DROP;
                     end else if (i_data == ETH_SFD) begin
                        state_q <= ST_DATA;
                     end else begin
                        pre_cnt_q <= pre_cnt_q + PCNT_W'(1);
                     end
                  end
                  ST_DATA: begin
                     // Four-byte delay line holds back the FCS; dl_q[3] is oldest.
                     dl_q  <= {dl_q[2:0], i_data};
                     len_q <= len_inc_c;
                     phy_q <= phy_q | i_err;
                     if (dl_cnt_q != DL_FULL) dl_cnt_q <= dl_cnt_q + 3'd1;
                     if (dl_cnt_q == DL_FULL) begin
                        o_data_q  <= dl_q[3];
                        o_val_q   <= 1'b1;
                        o_sof_q   <= ~started_q;
                        o_eof_q   <= i_eof;
                        started_q <= 1'b1;
                     end
                     if (i_eof) begin
                        st_val_q <= 1'b1;
                        st_q     <= make_status(crc_next_c != CRC32_RESIDUE, len_err_c,
                                                phy_q | i_err, 1'b0, 1'b0, len_inc_c);
                        state_q  <= ST_IDLE;
                     end
                  end
                  ST_DROP: begin
                     if (i_eof) state_q <= ST_IDLE;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign o_data     = o_data_q;
   assign o_val      = o_val_q;
   assign o_sof      = o_sof_q;
   assign o_eof      = o_eof_q;
   assign st_val     = st_val_q;
   assign st_good    = st_q.good;
   assign st_crc_err = st_q.crc_err;
   assign st_len_err = st_q.len_err;
   assign st_phy_err = st_q.phy_err;
   assign st_pre_err = st_q.pre_err;
   assign st_abort   = st_q.abort;
   assign st_len     = st_q.len;
   assign cnt_good   = cnt_good_q;
   assign cnt_bad    = cnt_bad_q;

endmodule

// File: doc/rgmii_rx_frame_checker.md
Name: rgmii_rx_frame_checker

Overview:
- Sits directly downstream of the RGMII over-clock receiver, in the clk125 domain.
- Consumes its byte stream: data, valid, PHY error, SoF, EoF, with SoF on the first preamble byte.
- Strips preamble/SFD and FCS, checks FCS (CRC-32), frame length and PHY error, and emits a payload byte stream (DA..last data byte) plus a per-frame status strobe and good/bad frame counters.

Parameters:
- MIN_LEN, 64, minimum frame length in bytes, DA..FCS inclusive.
- MAX_LEN, 1518, maximum frame length in bytes, DA..FCS inclusive.

Ports:
- clk125  in  1  system clock, 125 MHz.
- rst  in  1  synchronous reset, active-high.
- i_data  in  8  received byte.
- i_val  in  1  byte valid; all other i_* inputs qualified by i_val.
- i_err  in  1  PHY RX error for this byte.
- i_sof  in  1  first byte of frame (preamble).
- i_eof  in  1  last byte of frame (last FCS byte).
- o_data  out  8  payload byte.
- o_val  out  1  payload byte valid.
- o_sof  out  1  first payload byte (DA[0]).
- o_eof  out  1  last payload byte, or an eof-only beat when o_val=0 (abort).
- st_val  out  1  one-cycle frame status strobe.
- st_good  out  1  frame passed all checks.
- st_crc_err  out  1  FCS mismatch.
- st_len_err  out  1  length < MIN_LEN or > MAX_LEN.
- st_phy_err  out  1  i_err seen anywhere in frame.
- st_pre_err  out  1  bad preamble/SFD.
- st_abort  out  1  frame cut by new SoF before EoF.
- st_len  out  16  bytes DA..FCS, saturating at 0xFFFF.
- cnt_good  out  32  frames with st_good; wraps.
- cnt_bad  out  32  frames with st_val and !st_good; wraps.

Behaviour:
- Reset: every output 0; FSM to IDLE; delay line emptied; counters 0. Reset mid-frame discards the frame silently (no status, no count).
- Inputs with i_val=0 are ignored in every state. Gaps inside a frame are stalls, not errors.
- All outputs are registered.
- FSM IDLE:
  - i_sof -> PRE; the SoF byte must be 0x55.
  - SoF byte with i_eof, or SoF byte not 0x55 -> status pre_err; DROP if !i_eof, else stay IDLE.
- FSM PRE:
  - 0x55 increments the preamble count; more than 7 x 0x55 in total -> pre_err, DROP.
  - 0xD5 -> DATA, with CRC reg = 0xFFFFFFFF and len = 0.
  - Any other byte -> pre_err, DROP.
  - i_eof in PRE -> pre_err status, IDLE.
- FSM DATA:
  - Each byte: CRC update, reflected poly 0xEDB88320, LSB first; len++; byte shifted into a 4-deep delay line.
  - When the delay line is full, the oldest byte is output with o_val=1.
  - o_sof on the first byte output.
  - Latency: input byte N (N>=5 after SFD) releases byte N-4 one clock later.
- End of frame in DATA, i_eof on byte N:
  - If N>=5: byte N-4 is output with o_eof=1, and st_val is asserted in the same cycle.
  - If N<=4: no payload output; st_val only, with len_err and crc_err as computed.
  - Then IDLE.
- CRC check:
  - Pass iff the CRC register after the last FCS byte equals 0xDEBB20E3 (residue).
  - crc_err = !pass.
- Length check: len_err = (len < MIN_LEN) || (len > MAX_LEN). The counter keeps counting past MAX_LEN.
- phy_err: sticky from SoF to EoF.
- st_good = !(crc_err | len_err | phy_err | pre_err | abort).
- Abort: i_sof while in DATA.
  - Emit st_val with abort=1 and an eof-only beat (o_eof=1, o_val=0) if any payload was output; otherwise status only.
  - Delay line flushed; the new SoF byte is processed as in IDLE in the same cycle.
  - i_sof in PRE or DROP -> abort status, no payload (none was output); the new SoF byte is processed as in IDLE.
- FSM DROP: consume bytes until i_eof, then IDLE. No output, no second status.
- Counters: update the cycle after st_val.
- Status fields hold between strobes and are valid only with st_val.

Decomposition:
- Shared package rgmii_pkg holds:
  - CRC32_POLY_REFL = 32'hEDB88320.
  - CRC32_INIT = 32'hFFFFFFFF.
  - CRC32_RESIDUE = 32'hDEBB20E3.
  - ETH_PREAMBLE = 8'h55.
  - ETH_SFD = 8'hD5.
  - The FSM state enum.
- One sub-module, crc32_d8: 8-bit parallel CRC step, combinational, with an enable-registered wrapper.

Test Plan:
- Good 64-byte frame (7 x 0x55, 0xD5, 60 data bytes, correct FCS), contiguous i_val -> 60 o_val bytes with o_sof on DA[0] and o_eof on byte 60; st_good=1, st_len=64; cnt_good=1.
- Same frame with one FCS bit flipped and i_val gaps every 3rd cycle -> identical payload bytes; st_crc_err=1, st_good=0; cnt_bad=1.
- 60-byte frame with valid FCS -> st_len_err=1, st_len=60. Then a 1519-byte frame -> st_len_err=1, st_len=1519.
- Preamble byte 0x54 at position 3 -> no o_val; one st_val with st_pre_err=1. The following good frame passes normally.
- New i_sof after 20 bytes of DATA -> eof-only beat with st_abort=1; the next frame is received good. Also: i_err on a mid-frame byte -> st_phy_err=1.
- Frame of SFD + 3 bytes + i_eof -> no payload; st_val with st_len_err=1. Also: rst asserted mid-frame -> all outputs 0, no status, counters 0.
